// File: rtl/div_pkg.sv
// Shared types and constants for the sequential shift-subtract divider.
package div_pkg;

  localparam int DIV_WIDTH = 8;

  // The iteration counter needs at least one bit even for degenerate widths.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int DIV_CNT_W = cnt_width(DIV_WIDTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    SUB   = 3'd2,
    FIX   = 3'd3,
    DONE  = 3'd4
  } div_state_e;

endpackage

// File: rtl/div_control.sv
// FSM and iteration counter of the divider; emits datapath strobes.
// The FIX state is only reachable when SIGNED_DIV_EN is defined.
module div_control
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  input  logic load_div_i,
  input  logic d_zero_i,
  output logic ld_div_o,
  output logic load_q_o,
  output logic clr_o,
  output logic shift_o,
  output logic sub_en_o,
  output logic fix_o,
  output logic busy_o,
  output logic done_o
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ld_div_o = 1'b0;
    load_q_o = 1'b0;
    clr_o    = 1'b0;
    shift_o  = 1'b0;
    sub_en_o = 1'b0;
    fix_o    = 1'b0;
    unique case (state_q)
      IDLE: begin
        ld_div_o = load_div_i;
        if (run_i) begin
          load_q_o = 1'b1;
          clr_o    = 1'b1;
          cnt_d    = '0;
          state_d  = d_zero_i ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        shift_o = 1'b1;
        state_d = SUB;
      end
      SUB: begin
        sub_en_o = 1'b1;
        if (cnt_q == LAST) begin
`ifdef SIGNED_DIV_EN
          state_d = FIX;
`else
          state_d = DONE;
`endif
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = SHIFT;
        end
      end
      FIX: begin
        fix_o   = 1'b1;
        state_d = DONE;
      end
      // Waiting for Run to drop makes one key press yield one operation.
      DONE: begin
        if (!run_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q == SHIFT) || (state_q == SUB) || (state_q == FIX);
  assign done_o = (state_q == DONE);

endmodule

// File: rtl/seq_divider.sv
// Restoring shift-subtract divider: one quotient bit per two cycles.
// Define SIGNED_DIV_EN for two's-complement operands (adds a FIX cycle).
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Run,
  input  logic             Load_Divisor,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             Div_by_zero
);

  logic             ld_div, load_q, clr, shift, sub_en, fix;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] d_eff;
  logic             d_zero;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic             quo_neg, rem_neg;
  logic [WIDTH+1:0] diff;
  logic             sub_ok;

  div_control #(
    .WIDTH(WIDTH)
  ) u_ctrl (
    .clk_i     (Clk),
    .rst_ni    (Reset_n),
    .run_i     (Run),
    .load_div_i(Load_Divisor),
    .d_zero_i  (d_zero),
    .ld_div_o  (ld_div),
    .load_q_o  (load_q),
    .clr_o     (clr),
    .shift_o   (shift),
    .sub_en_o  (sub_en),
    .fix_o     (fix),
    .busy_o    (Busy),
    .done_o    (Done)
  );

  // A same-cycle load wins, so the zero check sees the divisor about to be used.
  assign d_eff  = ld_div ? Din : d_q;
  assign d_zero = (d_eff == '0);

`ifdef SIGNED_DIV_EN
  logic neg_q, sdiff_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      neg_q   <= 1'b0;
      sdiff_q <= 1'b0;
    end else if (load_q) begin
      neg_q   <= Din[WIDTH-1];
      sdiff_q <= Din[WIDTH-1] ^ d_eff[WIDTH-1];
    end
  end

  assign dvd_mag = Din[WIDTH-1] ? -Din : Din;
  assign dvs_mag = d_q[WIDTH-1] ? -d_q : d_q;
  assign quo_neg = sdiff_q;
  assign rem_neg = neg_q;
`else
  assign dvd_mag = Din;
  assign dvs_mag = d_q;
  assign quo_neg = 1'b0;
  assign rem_neg = 1'b0;
`endif

  assign diff   = {1'b0, r_q} - {2'b00, dvs_mag};
  assign sub_ok = ~diff[WIDTH+1];

  always_comb begin
    q_d  = q_q;
    r_d  = r_q;
    d_d  = d_q;
    dz_d = dz_q;
    if (ld_div) d_d = Din;
    if (clr) r_d = '0;
    // Divide by zero skips the iterations and parks the dividend in R.
    if (load_q) begin
      dz_d = d_zero;
      if (d_zero) begin
        q_d = '1;
        r_d = {1'b0, Din};
      end else begin
        q_d = dvd_mag;
      end
    end
    if (shift) begin
      r_d = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
      q_d = {q_q[WIDTH-2:0], 1'b0};
    end
    if (sub_en) begin
      if (sub_ok) r_d = diff[WIDTH:0];
      q_d[0] = sub_ok;
    end
    if (fix) begin
      if (quo_neg) q_d = -q_q;
      if (rem_neg) r_d = -r_q;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      q_q  <= '0;
      r_q  <= '0;
      d_q  <= '0;
      dz_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      r_q  <= r_d;
      d_q  <= d_d;
      dz_q <= dz_d;
    end
  end

  assign Quotient    = q_q;
  assign Remainder   = r_q[WIDTH-1:0];
  assign Div_by_zero = dz_q;

endmodule
